// File: rtl/instr_queue_mw_pkg.sv
// Shared fetch/decode definitions: default widths and the {pc, inst} instruction record
// used by the instruction queue and the if_id/id stages.
package instr_queue_mw_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned INST_WIDTH_DEF = 32;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] pc;
        logic [INST_WIDTH_DEF-1:0] inst;
    } instr_rec_t;

endpackage

// File: rtl/instq_lane_compact.sv
// Prefix popcount over a lane mask: offset_o[k] is the number of set lanes below k,
// total_o the number of set lanes. Used for push compaction and pop counting.
module instq_lane_compact #(
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]            valid_i,
    output logic [LANES-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]            total_o
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int k = 0; k < LANES; k++) begin
            offset_o[k] = acc;
            acc         = acc + CNT_W'(valid_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/instr_queue_mw.sv
// Multi-lane first-word-fall-through instruction queue between fetch and decode.
// Optional build macro INSTQ_PERF_CNT_EN adds saturating full-stall / empty cycle counters.
module instr_queue_mw
    import instr_queue_mw_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned INST_WIDTH  = INST_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic [FETCH_WIDTH-1:0]            push_valid_i,
    input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] push_pc_i,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] push_inst_i,
    output logic                              push_ready_o,
    output logic [ISSUE_WIDTH-1:0]            out_valid_o,
    output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] out_pc_o,
    output logic [ISSUE_WIDTH*INST_WIDTH-1:0] out_inst_o,
    input  logic [ISSUE_WIDTH-1:0]            issue_ready_i,
    output logic [$clog2(DEPTH):0]            count_o
`ifdef INSTQ_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_full_stall_o,
    output logic [31:0]                       perf_empty_o
`endif
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned FCW = $clog2(FETCH_WIDTH + 1);
    localparam int unsigned ICW = $clog2(ISSUE_WIDTH + 1);
    localparam logic [CW-1:0] PushMax = CW'(DEPTH - FETCH_WIDTH);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [INST_WIDTH-1:0] inst_q [DEPTH];

    logic [FETCH_WIDTH-1:0][FCW-1:0] push_off;
    logic [FCW-1:0]                  push_cnt, push_n;
    logic [ISSUE_WIDTH-1:0]          pop_en;
    logic [ISSUE_WIDTH-1:0][ICW-1:0] pop_off;
    logic [ICW-1:0]                  pop_cnt;
    logic                            unused_pop_off;

    instq_lane_compact #(
        .LANES (FETCH_WIDTH)
    ) u_push_compact (
        .valid_i  (push_valid_i),
        .offset_o (push_off),
        .total_o  (push_cnt)
    );

    instq_lane_compact #(
        .LANES (ISSUE_WIDTH)
    ) u_pop_count (
        .valid_i  (pop_en),
        .offset_o (pop_off),
        .total_o  (pop_cnt)
    );

    assign unused_pop_off = ^pop_off;

    // Readiness looks at current occupancy only; same-cycle pops are not credited.
    assign push_ready_o = (count_q <= PushMax);
    assign push_n       = push_ready_o ? push_cnt : '0;
    assign count_o      = count_q;

    always_comb begin
        out_valid_o = '0;
        out_pc_o    = '0;
        out_inst_o  = '0;
        pop_en      = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            out_valid_o[j]                      = (count_q > CW'(j));
            out_pc_o[j*ADDR_WIDTH +: ADDR_WIDTH] = pc_q[head_q + PW'(j)];
            out_inst_o[j*INST_WIDTH +: INST_WIDTH] = inst_q[head_q + PW'(j)];
            pop_en[j] = out_valid_o[j] && issue_ready_i[j] && ((j == 0) || pop_en[(j == 0) ? 0 : j-1]);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_cnt);
            tail_d  = tail_q + PW'(push_n);
            count_d = count_q + CW'(push_n) - CW'(pop_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!flush_i && push_ready_o) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (push_valid_i[k]) begin
                    pc_q[tail_q + PW'(push_off[k])]   <= push_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    inst_q[tail_q + PW'(push_off[k])] <= push_inst_i[k*INST_WIDTH +: INST_WIDTH];
                end
            end
        end
    end

`ifdef INSTQ_PERF_CNT_EN
    logic [31:0] full_stall_q, empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_stall_q <= '0;
            empty_q      <= '0;
        end else begin
            if ((|push_valid_i) && !push_ready_o && (full_stall_q != '1)) begin
                full_stall_q <= full_stall_q + 32'd1;
            end
            if ((count_q == '0) && (empty_q != '1)) begin
                empty_q <= empty_q + 32'd1;
            end
        end
    end

    assign perf_full_stall_o = full_stall_q;
    assign perf_empty_o      = empty_q;
`endif

endmodule

// File: tb/tb_instr_queue_mw.sv
// Scoreboard bench for instr_queue_mw: expected entries queued on accepted pushes,
// compared against the output lanes and retired on modelled pops.
module tb_instr_queue_mw;

    localparam int F = 2;
    localparam int I = 2;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic [F-1:0]  push_valid_i;
    logic [F*32-1:0] push_pc_i;
    logic [F*32-1:0] push_inst_i;
    logic          push_ready_o;
    logic [I-1:0]  out_valid_o;
    logic [I*32-1:0] out_pc_o;
    logic [I*32-1:0] out_inst_o;
    logic [I-1:0]  issue_ready_i;
    logic [3:0]    count_o;
`ifdef INSTQ_PERF_CNT_EN
    logic [31:0]   perf_full_stall_o;
    logic [31:0]   perf_empty_o;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    rec_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] next_pc;

    always #5 clk = ~clk;

    instr_queue_mw #(
        .DEPTH       (D),
        .FETCH_WIDTH (F),
        .ISSUE_WIDTH (I),
        .ADDR_WIDTH  (32),
        .INST_WIDTH  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .push_valid_i  (push_valid_i),
        .push_pc_i     (push_pc_i),
        .push_inst_i   (push_inst_i),
        .push_ready_o  (push_ready_o),
        .out_valid_o   (out_valid_o),
        .out_pc_o      (out_pc_o),
        .out_inst_o    (out_inst_o),
        .issue_ready_i (issue_ready_i),
        .count_o       (count_o)
`ifdef INSTQ_PERF_CNT_EN
        ,
        .perf_full_stall_o (perf_full_stall_o),
        .perf_empty_o      (perf_empty_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h0000_0013;
    endfunction

    // Drive one cycle of stimulus, check outputs at the falling edge, then update the model.
    task automatic step(input logic [1:0] v, input logic [1:0] rdy, input logic fl);
        int   npop;
        logic pready;
        rec_t r;
        push_valid_i  = v;
        issue_ready_i = rdy;
        flush_i       = fl;
        for (int k = 0; k < F; k++) begin
            if (v[k]) begin
                push_pc_i[k*32 +: 32]   = next_pc;
                push_inst_i[k*32 +: 32] = inst_of(next_pc);
                next_pc = next_pc + 32'd4;
            end else begin
                push_pc_i[k*32 +: 32]   = 32'hbad0_0000;
                push_inst_i[k*32 +: 32] = 32'h0;
            end
        end
        @(negedge clk);
        pready = (sb.size() <= D - F);
        check_eq("count", 64'(count_o), 64'(sb.size()));
        check_eq("push_ready", 64'(push_ready_o), 64'(pready));
        for (int j = 0; j < I; j++) begin
            check_eq("out_valid", 64'(out_valid_o[j]), 64'(sb.size() > j));
            if (sb.size() > j) begin
                check_eq("out_pc", 64'(out_pc_o[j*32 +: 32]), 64'(sb[j].pc));
                check_eq("out_inst", 64'(out_inst_o[j*32 +: 32]), 64'(sb[j].inst));
            end
        end
        if (fl) begin
            sb.delete();
        end else begin
            npop = 0;
            for (int j = 0; j < I; j++) begin
                if (j == npop && sb.size() > j && rdy[j]) npop++;
            end
            repeat (npop) void'(sb.pop_front());
            if (pready) begin
                for (int k = 0; k < F; k++) begin
                    if (v[k]) begin
                        r.pc   = push_pc_i[k*32 +: 32];
                        r.inst = push_inst_i[k*32 +: 32];
                        sb.push_back(r);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        push_valid_i  = '0;
        issue_ready_i = '0;
        flush_i       = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        push_valid_i  = '0;
        push_pc_i     = '0;
        push_inst_i   = '0;
        issue_ready_i = '0;
        next_pc       = 32'h1c00_0000;
        #12;
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_ready", 64'(push_ready_o), 64'd1);
        check_eq("rst_valid", 64'(out_valid_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Dual push, then single push on lane 1 into an empty queue.
        step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        step(2'b00, 2'b11, 1'b0);

        // Fill to 7; a further push is dropped.
        repeat (3) step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);

        // Down to 4, non-prefix ready, then steady push+pop across the wrap.
        step(2'b00, 2'b11, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b10, 1'b0);
        repeat (5) step(2'b11, 2'b11, 1'b0);

        // Count 5, flush with a simultaneous push and pop.
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b1);
        step(2'b00, 2'b00, 1'b0);

        // Count 6, then an asynchronous reset pulse away from the clock edge.
        repeat (3) step(2'b11, 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("async_rst_count", 64'(count_o), 64'd0);
        check_eq("async_rst_valid", 64'(out_valid_o), 64'd0);
        check_eq("async_rst_ready", 64'(push_ready_o), 64'd1);
        sb.delete();
        #2;
        rst = 1'b0;
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b11, 1'b0);

        repeat (300) begin
            step(2'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
